// File: rtl/hilo_mult_controller_pkg.sv
// ----------------------------------------------------------------------------
// hilo_mult_controller_pkg
// Shared definitions for the HI/LO multiply path:
//   - MulOp encodings driven by the EX stage
//   - controller state encodings
//   - default operand width and the ALU control code that routes ops here
// ----------------------------------------------------------------------------
package hilo_mult_controller_pkg;

    localparam int          WIDTH_DEF     = 32;
    localparam logic [3:0]  ALU_CTRL_MULT = 4'b1111;

    typedef enum logic [2:0] {
        MUL_MULT  = 3'b000,
        MUL_MULTU = 3'b001,
        MUL_MADD  = 3'b010,
        MUL_MSUB  = 3'b011,
        MUL_MTHI  = 3'b100,
        MUL_MTLO  = 3'b101
    } mulop_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        ACC  = 2'b10,
        DONE = 2'b11
    } state_t;

    // mult, multu, madd and msub all live in the lower half of the code space
    function automatic logic is_mul_class(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    // mult, madd and msub operate on signed operands; multu does not
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MUL_MULT) || (op == MUL_MADD) || (op == MUL_MSUB);
    endfunction

endpackage

// File: rtl/hilo_mult_controller_mul_shift_add_core.sv
// ----------------------------------------------------------------------------
// mul_shift_add_core
// Unsigned WIDTH x WIDTH iterative shift-add multiplier, one bit per step.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   load       clear accumulator/counter and capture both operands
//   step       perform one shift-add iteration
//   mcand_in   multiplicand (unsigned)
//   mplier_in  multiplier (unsigned)
//   product    2*WIDTH-bit accumulator; holds the full product after WIDTH steps
//   last       high during the step that completes the final iteration
// ----------------------------------------------------------------------------
module mul_shift_add_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     upper_sum;

    // The add into the upper half can carry out one bit; that carry becomes
    // the top bit of the accumulator after the right shift.
    always_comb begin
        upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= '0;
            cnt <= '0;
        end else if (step) begin
            acc <= {upper_sum, acc[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
        end
    end

    // Operand registers are pure data; load always precedes their use.
    always_ff @(posedge clk) begin
        if (load) begin
            mcand  <= mcand_in;
            mplier <= mplier_in;
        end else if (step) begin
            mplier <= mplier >> 1;
        end
    end

    assign product = acc;
    assign last    = step && (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/hilo_mult_controller.sv
// ----------------------------------------------------------------------------
// hilo_mult_controller
// Multi-cycle sequencer for the HI/LO multiply path (mult, multu, madd, msub,
// mthi, mtlo). Runs an iterative shift-add multiply, commits HI/LO and stalls
// the pipeline while a multiply is in flight.
// Ports:
//   Clk, Rst   clock and asynchronous active-high reset
//   Start      request strobe, sampled only in IDLE or DONE
//   MulOp      operation code (see hilo_mult_controller_pkg::mulop_t)
//   A, B       rs / rt operands (B unused for mthi/mtlo)
//   Busy       stall request, high in CALC and ACC
//   Done       one-cycle pulse in the cycle after a multiply result commits
//   HI, LO     architectural HI/LO registers
// ----------------------------------------------------------------------------
module hilo_mult_controller
    import hilo_mult_controller_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       MulOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    // 0x80000000 maps to itself, read back as an unsigned magnitude
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic signed [2*WIDTH-1:0] v,
                                                      input logic neg);
        return neg ? (2*WIDTH)'(-v) : (2*WIDTH)'(v);
    endfunction

    state_t             state, state_nxt;
    mulop_t             op_q;
    logic               sign_q;
    logic               can_start;
    logic               mul_accept;
    logic               mthi_wr;
    logic               mtlo_wr;
    logic               signed_op;
    logic [WIDTH-1:0]   mcand_in;
    logic [WIDTH-1:0]   mplier_in;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_s;
    logic [2*WIDTH-1:0] hilo_new;
    logic               last;

    assign can_start  = Start && ((state == IDLE) || (state == DONE));
    assign mul_accept = can_start && is_mul_class(MulOp);
    assign mthi_wr    = can_start && (MulOp == MUL_MTHI);
    assign mtlo_wr    = can_start && (MulOp == MUL_MTLO);
    assign signed_op  = is_signed_op(MulOp);
    assign mcand_in   = signed_op ? magnitude(A) : A;
    assign mplier_in  = signed_op ? magnitude(B) : B;

    mul_shift_add_core #(.WIDTH(WIDTH)) u_core (
        .clk       (Clk),
        .rst       (Rst),
        .load      (mul_accept),
        .step      (state == CALC),
        .mcand_in  (mcand_in),
        .mplier_in (mplier_in),
        .product   (product),
        .last      (last)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (mul_accept) state_nxt = CALC;
            CALC: if (last)       state_nxt = ACC;
            ACC:                  state_nxt = DONE;
            DONE: state_nxt = mul_accept ? CALC : IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    assign Busy = (state == CALC) || (state == ACC);
    assign Done = (state == DONE);

    // Operation and result sign are only consumed after an accept loads them.
    always_ff @(posedge Clk) begin
        if (mul_accept) begin
            op_q   <= mulop_t'(MulOp);
            sign_q <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
        end
    end

    // ACC stage: sign the magnitude product and fold it into HI/LO
    always_comb begin
        product_s = apply_sign(product, sign_q);
        case (op_q)
            MUL_MADD: hilo_new = {HI, LO} + product_s;
            MUL_MSUB: hilo_new = {HI, LO} - product_s;
            default:  hilo_new = product_s;
        endcase
    end

    // mthi/mtlo are only accepted in IDLE/DONE, so they never collide with ACC
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            HI <= '0;
            LO <= '0;
        end else if (state == ACC) begin
            {HI, LO} <= hilo_new;
        end else begin
            if (mthi_wr) HI <= A;
            if (mtlo_wr) LO <= A;
        end
    end

endmodule

// File: tb/tb_hilo_mult_controller.sv
// ----------------------------------------------------------------------------
// tb_hilo_mult_controller
// Directed bench for hilo_mult_controller: reset, multu/mult, mthi/mtlo with
// madd/msub, Start while busy, reset mid-multiply and back-to-back issue.
// ----------------------------------------------------------------------------
module tb_hilo_mult_controller;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [2:0]  MulOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int vectors;
    int miscompares;

    hilo_mult_controller #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .MulOp (MulOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .HI    (HI),
        .LO    (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Present a request for one edge; returns #1 after the sampling edge
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MulOp = op;
        A     = a;
        B     = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        A     = '0;
        B     = '0;
    endtask

    // Called in cycle k+1 of a multiply. Returns in the Done cycle with
    // done_at = cycle index relative to the accept edge (0 on timeout).
    // inject_at > 0 raises a mult 9x9 Start for one cycle at that index.
    task automatic wait_done(input int inject_at, output int done_at, output int busy_cnt);
        done_at  = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == inject_at) begin
                Start = 1'b1; MulOp = 3'b000; A = 32'd9; B = 32'd9;
            end else if (i == inject_at + 1) begin
                Start = 1'b0; A = '0; B = '0;
            end
            if (Done) begin
                done_at = i;
                break;
            end
            if (Busy) busy_cnt++;
            @(posedge Clk);
            #1;
        end
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; MulOp = '0; A = '0; B = '0;
        repeat (2) @(posedge Clk);
        #1;
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", Busy); end
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", Done); end
        vectors++; if (HI !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h want 0", HI); end
        vectors++; if (LO !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h want 0", LO); end
        Rst = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_multu();
        int d, bc;
        start_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, d, bc);
        vectors++; if (d !== 34) begin miscompares++; $display("FAIL multu_done_at got %0d want 34", d); end
        vectors++; if (bc !== 33) begin miscompares++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
        vectors++; if (HI !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi got %h want fffffffe", HI); end
        vectors++; if (LO !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo got %h want 00000001", LO); end
        @(posedge Clk);
        #1;
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL multu_done_single got %b want 0", Done); end
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL multu_idle_busy got %b want 0", Busy); end
    endtask

    task automatic test_mult_signed();
        int d, bc;
        start_op(3'b000, 32'hFFFFFFFD, 32'd5);
        wait_done(0, d, bc);
        vectors++; if (d !== 34) begin miscompares++; $display("FAIL mult_neg_done_at got %0d want 34", d); end
        vectors++; if (HI !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_neg_hi got %h want ffffffff", HI); end
        vectors++; if (LO !== 32'hFFFFFFF1) begin miscompares++; $display("FAIL mult_neg_lo got %h want fffffff1", LO); end
        @(posedge Clk);
        #1;
        start_op(3'b000, 32'h80000000, 32'h80000000);
        wait_done(0, d, bc);
        vectors++; if (HI !== 32'h40000000) begin miscompares++; $display("FAIL mult_min_hi got %h want 40000000", HI); end
        vectors++; if (LO !== 32'h00000000) begin miscompares++; $display("FAIL mult_min_lo got %h want 00000000", LO); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_mthi_mtlo_madd();
        int d, bc;
        start_op(3'b100, 32'h12345678, 32'hDEADBEEF);
        vectors++; if (HI !== 32'h12345678) begin miscompares++; $display("FAIL mthi_hi got %h want 12345678", HI); end
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL mthi_busy got %b want 0", Busy); end
        start_op(3'b101, 32'h0, 32'h0);
        vectors++; if (LO !== 32'h0) begin miscompares++; $display("FAIL mtlo_lo got %h want 0", LO); end
        vectors++; if (Done !== 1'b0) begin miscompares++; $display("FAIL mtlo_done got %b want 0", Done); end
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL mtlo_busy got %b want 0", Busy); end
        start_op(3'b010, 32'd2, 32'd3);
        wait_done(0, d, bc);
        vectors++; if (d !== 34) begin miscompares++; $display("FAIL madd_done_at got %0d want 34", d); end
        vectors++; if (HI !== 32'h12345678) begin miscompares++; $display("FAIL madd_hi got %h want 12345678", HI); end
        vectors++; if (LO !== 32'h00000006) begin miscompares++; $display("FAIL madd_lo got %h want 00000006", LO); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_msub_ignore_busy();
        int d, bc;
        start_op(3'b100, 32'h0, 32'h0);
        start_op(3'b101, 32'd5, 32'h0);
        vectors++; if (LO !== 32'd5) begin miscompares++; $display("FAIL mtlo5_lo got %h want 00000005", LO); end
        start_op(3'b011, 32'd1, 32'd7);
        wait_done(10, d, bc);
        vectors++; if (d !== 34) begin miscompares++; $display("FAIL msub_done_at got %0d want 34", d); end
        vectors++; if (bc !== 33) begin miscompares++; $display("FAIL msub_busy_cycles got %0d want 33", bc); end
        vectors++; if (HI !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL msub_hi got %h want ffffffff", HI); end
        vectors++; if (LO !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL msub_lo got %h want fffffffe", LO); end
        @(posedge Clk);
        #1;
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL ignored_start_busy got %b want 0", Busy); end
        vectors++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE) begin
            miscompares++; $display("FAIL ignored_start_hilo got %h_%h want ffffffff_fffffffe", HI, LO);
        end
    endtask

    task automatic test_reset_mid_calc();
        int d, bc;
        int seen_done;
        start_op(3'b000, 32'd100, 32'd100);
        repeat (9) @(posedge Clk);
        #1;
        Rst = 1'b1;
        #1;
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", Busy); end
        vectors++; if (HI !== 32'h0) begin miscompares++; $display("FAIL rstmid_hi got %h want 0", HI); end
        vectors++; if (LO !== 32'h0) begin miscompares++; $display("FAIL rstmid_lo got %h want 0", LO); end
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done || Busy) seen_done++;
            @(posedge Clk);
            #1;
        end
        vectors++; if (seen_done !== 0) begin miscompares++; $display("FAIL rstmid_no_done got %0d active cycles want 0", seen_done); end
        start_op(3'b000, 32'd7, 32'd6);
        wait_done(0, d, bc);
        vectors++; if (d !== 34) begin miscompares++; $display("FAIL post_rst_done_at got %0d want 34", d); end
        vectors++; if (LO !== 32'h0000002A) begin miscompares++; $display("FAIL post_rst_lo got %h want 0000002a", LO); end
        vectors++; if (HI !== 32'h0) begin miscompares++; $display("FAIL post_rst_hi got %h want 0", HI); end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int d, bc;
        start_op(3'b001, 32'd3, 32'd4);
        wait_done(0, d, bc);
        vectors++; if (LO !== 32'd12) begin miscompares++; $display("FAIL b2b_first_lo got %h want 0000000c", LO); end
        // still in the DONE cycle: issue the next op with no idle gap
        start_op(3'b010, 32'd1, 32'd1);
        vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_after_done got %b want 1", Busy); end
        wait_done(0, d, bc);
        vectors++; if (d !== 34) begin miscompares++; $display("FAIL b2b_done_at got %0d want 34", d); end
        vectors++; if (bc !== 33) begin miscompares++; $display("FAIL b2b_busy_cycles got %0d want 33", bc); end
        vectors++; if (LO !== 32'd13) begin miscompares++; $display("FAIL b2b_lo got %h want 0000000d", LO); end
        vectors++; if (HI !== 32'h0) begin miscompares++; $display("FAIL b2b_hi got %h want 0", HI); end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_multu();
        test_mult_signed();
        test_mthi_mtlo_madd();
        test_msub_ignore_busy();
        test_reset_mid_calc();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hilo_mult_controller.md
# hilo_mult_controller

Multi-cycle sequencer for the HI/LO multiply path of the single-issue MIPS datapath. It accepts mult, multu, madd, msub, mthi and mtlo from the EX stage and runs an iterative 32-step shift-add multiply. It then updates the architectural HI/LO registers and holds the pipeline stall line while the operation is in flight. It sits beside the ALU. ALU control op 1111 ("multiply") is routed here instead of the combinational ALU.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, the product is 2*WIDTH bits.
- Clk  in  1  single clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  request strobe; sampled only when the block is idle.
- MulOp  in  3  operation code: 000 mult, 001 multu, 010 madd, 011 msub, 100 mthi, 101 mtlo. 110 and 111 are ignored.
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand; unused for mthi/mtlo.
- Busy  out  1  pipeline stall request.
- Done  out  1  one-cycle pulse when a multiply result is committed.
- HI  out  WIDTH  architectural HI register.
- LO  out  WIDTH  architectural LO register.

## Operation
- Reset values: state IDLE, Busy=0, Done=0, HI=0, LO=0, iteration counter=0, internal accumulator=0.
- States and transitions:
  - IDLE → CALC: on Start with a multiply-class MulOp.
  - CALC → ACC: after the 32nd iteration.
  - ACC → DONE.
  - DONE → IDLE, or DONE → CALC if Start with a multiply-class op is sampled in DONE.
- mthi/mtlo:
  - Accepted in IDLE or DONE. The edge that samples Start writes A into HI or LO.
  - No state change, Busy stays 0, no Done pulse.
- On multiply accept:
  - Latch MulOp, and the magnitudes of A and B (signed ops) or the raw values (unsigned ops).
  - Latch the result sign (A[31]^B[31] for signed ops, 0 for unsigned).
  - Clear the product accumulator and the counter.
- CALC, one iteration per cycle: if multiplier bit 0 is 1, add the multiplicand into the upper half of the 64-bit accumulator. Then shift the accumulator and multiplier right by 1. Counter 0..31.
- ACC:
  - Two's-complement negate the product if the result sign is 1.
  - mult/multu: {HI,LO} = product.
  - madd: {HI,LO} = {HI,LO} + product, mod 2^64.
  - msub: {HI,LO} = {HI,LO} − product, mod 2^64.
  - HI/LO are written on the edge that leaves ACC.
- Magnitude of 0x80000000 is 0x80000000 treated as unsigned 32-bit. No overflow or exception is raised.
- Busy = (state==CALC) || (state==ACC), decoded from registered state only; it must not depend combinationally on Start.
- Start while Busy=1 is ignored; operands are not re-latched.
- Invalid MulOp (110, 111) with Start: ignored, no state change.

## Timing
- Start sampled at edge k:
  - CALC occupies cycles k+1..k+32.
  - ACC occupies cycle k+33.
  - HI/LO take the new value at edge k+34.
  - Done=1 for cycle k+34 only.
- Busy is high for exactly 33 cycles per multiply; throughput is one multiply per 34 cycles.
- mthi/mtlo latency is 1 edge. The result is visible on HI/LO the cycle after Start.
- Back-to-back: a Start sampled in DONE (cycle k+34) enters CALC at k+35. The madd/msub accumulate reads the HI/LO already committed at k+34.
- Rst asserted at any point, including mid-CALC: outputs go to reset values immediately, with no edge needed. No Done pulse is generated and the partial product is discarded.

## Structure
- Shared package holds:
  - MulOp encodings: MUL_MULT, MUL_MULTU, MUL_MADD, MUL_MSUB, MUL_MTHI, MUL_MTLO.
  - State encodings: IDLE, CALC, ACC, DONE.
  - The WIDTH default and the ALU control code 1111 that routes ops here.
- One sub-module: mul_shift_add_core. It is the unsigned WIDTH×WIDTH iterative datapath (accumulator, multiplier shift register, counter) with load/step inputs and a last-iteration flag.
- The controller FSM, sign handling, madd/msub accumulate and the HI/LO registers live in hilo_mult_controller.

## Test plan
- multu A=0xFFFFFFFF B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; Busy high 33 cycles; Done pulses once at k+34.
- mult A=0xFFFFFFFD (−3) B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Also mult A=B=0x80000000 → HI=0x40000000, LO=0x00000000.
- mthi A=0x12345678, then mtlo A=0 on the next cycle, then madd A=2 B=3 → HI=0x12345678, LO=0x00000006. Neither mthi nor mtlo raises Busy or Done.
- mtlo A=5, then msub A=1 B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. Start with mult A=9 B=9 asserted at cycle k+10 (while Busy) → ignored, result unchanged.
- mult A=100 B=100 started, Rst asserted at cycle k+10 → Busy=0, HI=LO=0 immediately, no Done. After release, mult A=7 B=6 → LO=0x0000002A at k'+34.
- Start in the DONE cycle with madd A=1 B=1 after multu 3×4 (LO=12) → no idle gap; LO=13 at the following k+34.
